// File: rtl/beep_scheduler.sv
// Buzzer request arbiter: turns key clicks, the done melody and the alarm
// into timed one-hot note codes (NOTE/GAP pairs) for the tone generator.
module beep_scheduler #(
  parameter int unsigned NOTE_TICKS = 1250000,
  parameter int unsigned GAP_TICKS  = 250000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] key_req,
  input  logic       done_req,
  input  logic       alarm_en,
  output logic [7:0] note,
  output logic       busy,
  output logic [1:0] src
);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_KEY   = 2'd1,
    SRC_DONE  = 2'd2,
    SRC_ALARM = 2'd3
  } src_t;

  localparam logic [21:0] NOTE_LOAD = 22'(NOTE_TICKS - 1);
  localparam logic [21:0] GAP_LOAD  = 22'(GAP_TICKS - 1);

  state_t      state, state_n;
  src_t        src_q, src_n;
  logic [21:0] cnt, cnt_n;
  logic [1:0]  step, step_n;
  logic        done_pend, pend_n;
  logic [7:0]  key_prev;
  logic        alarm_prev;
  logic [7:0]  note_q, note_n;
  logic        busy_q, busy_n;

  logic [7:0]  rise;
  logic        key_valid;
  logic        alarm_rise;
  logic        launch;
  src_t        launch_src;
  logic [1:0]  launch_step;

  assign rise       = key_req & ~key_prev;
  assign key_valid  = ($countones(rise) == 1);
  assign alarm_rise = alarm_en & ~alarm_prev;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_q      <= SRC_NONE;
      cnt        <= '0;
      step       <= '0;
      done_pend  <= 1'b0;
      key_prev   <= '0;
      alarm_prev <= 1'b0;
      note_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      src_q      <= src_n;
      cnt        <= cnt_n;
      step       <= step_n;
      done_pend  <= pend_n;
      key_prev   <= key_req;
      alarm_prev <= alarm_en;
      note_q     <= note_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    src_n       = src_q;
    cnt_n       = cnt;
    step_n      = step;
    note_n      = note_q;
    busy_n      = busy_q;
    pend_n      = done_pend;
    launch      = 1'b0;
    launch_src  = SRC_NONE;
    launch_step = '0;

    // done_req is dropped only while a melody is already playing
    if (done_req && !(state != IDLE && src_q == SRC_DONE))
      pend_n = 1'b1;

    case (state)
      IDLE: begin
        if (alarm_en) begin
          launch     = 1'b1;
          launch_src = SRC_ALARM;
        end else if (done_req || done_pend) begin
          launch     = 1'b1;
          launch_src = SRC_DONE;
        end else if (key_valid) begin
          launch     = 1'b1;
          launch_src = SRC_KEY;
        end
      end
      NOTE: begin
        if (alarm_rise) begin
          launch     = 1'b1;
          launch_src = SRC_ALARM;
          if (src_q == SRC_DONE)
            pend_n = 1'b1;
        end else if ((src_q == SRC_ALARM && !alarm_en) || cnt == '0) begin
          state_n = GAP;
          cnt_n   = GAP_LOAD;
          note_n  = '0;
        end else begin
          cnt_n = cnt - 22'd1;
        end
      end
      GAP: begin
        if (alarm_rise) begin
          launch     = 1'b1;
          launch_src = SRC_ALARM;
          if (src_q == SRC_DONE)
            pend_n = 1'b1;
        end else if (cnt == '0) begin
          if (alarm_en) begin
            launch      = 1'b1;
            launch_src  = SRC_ALARM;
            launch_step = (src_q == SRC_ALARM) ? step + 2'd1 : 2'd0;
          end else if (src_q == SRC_DONE && step != 2'd3) begin
            launch      = 1'b1;
            launch_src  = SRC_DONE;
            launch_step = step + 2'd1;
          end else if (done_pend || done_req) begin
            launch     = 1'b1;
            launch_src = SRC_DONE;
          end else begin
            state_n = IDLE;
            src_n   = SRC_NONE;
            cnt_n   = '0;
            step_n  = '0;
            note_n  = '0;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - 22'd1;
        end
      end
      default: begin
        state_n = IDLE;
        src_n   = SRC_NONE;
        cnt_n   = '0;
        step_n  = '0;
        note_n  = '0;
        busy_n  = 1'b0;
      end
    endcase

    if (launch) begin
      state_n = NOTE;
      cnt_n   = NOTE_LOAD;
      step_n  = launch_step;
      src_n   = launch_src;
      busy_n  = 1'b1;
      case (launch_src)
        SRC_ALARM: note_n = launch_step[0] ? 8'h01 : 8'h04;
        SRC_DONE: begin
          pend_n = 1'b0;
          case (launch_step)
            2'd0:    note_n = 8'h80;
            2'd1:    note_n = 8'h20;
            2'd2:    note_n = 8'h08;
            default: note_n = 8'h01;
          endcase
        end
        SRC_KEY: note_n = rise;
        default: note_n = '0;
      endcase
    end
  end

  assign note = note_q;
  assign busy = busy_q;
  assign src  = src_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed bench for beep_scheduler with short note/gap timing; outputs are
// sampled 1 time unit after each rising edge.
module tb_beep_scheduler;

  localparam int unsigned NT = 10;
  localparam int unsigned GT = 3;

  logic       sys_clk;
  logic       rst_n;
  logic [7:0] key_req;
  logic       done_req;
  logic       alarm_en;
  logic [7:0] note;
  logic       busy;
  logic [1:0] src;

  int n_checks = 0;
  int n_fail   = 0;

  beep_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .key_req  (key_req),
    .done_req (done_req),
    .alarm_en (alarm_en),
    .note     (note),
    .busy     (busy),
    .src      (src)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] mel_code(int i);
    case (i)
      0:       return 8'h80;
      1:       return 8'h20;
      2:       return 8'h08;
      default: return 8'h01;
    endcase
  endfunction

  // expected {note,busy,src} m cycles into a melody that started at m=1
  function automatic logic [10:0] mel_exp(int m);
    int idx;
    int pos;
    idx = (m - 1) / 13;
    pos = (m - 1) % 13;
    if (m < 1 || m > 52) return 11'd0;
    return {(pos < 10) ? mel_code(idx) : 8'h00, 1'b1, 2'd2};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; key_req = '0; done_req = 1'b0; alarm_en = 1'b0;
    tick(); tick();
    n_checks++;
    if ({note, busy, src} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got note=%h busy=%b src=%0d, want 00/0/0", note, busy, src);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if ({note, busy, src} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: got note=%h busy=%b src=%0d, want 00/0/0", k, note, busy, src);
      end
    end
  endtask

  task automatic test_key_click();
    logic [10:0] e;
    key_req = 8'h10;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = {(k <= 10) ? 8'h10 : 8'h00, k <= 13, (k <= 13) ? 2'd1 : 2'd0};
      n_checks++;
      if ({note, busy, src} !== e) begin
        n_fail++;
        $display("FAIL key_click k=%0d: got %h/%b/%0d, want %h/%b/%0d", k, note, busy, src, e[10:3], e[2], e[1:0]);
      end
    end
    key_req = '0;
    tick();
  endtask

  task automatic test_invalid_key();
    key_req = 8'h30;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if ({note, busy, src} !== 11'd0) begin
        n_fail++;
        $display("FAIL invalid_key k=%0d: got %h/%b/%0d, want 00/0/0", k, note, busy, src);
      end
    end
    key_req = '0;
    tick();
  endtask

  task automatic test_key_late();
    logic [10:0] e;
    key_req = 8'h01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 7) key_req = 8'h09;
      e = {(k <= 10) ? 8'h01 : 8'h00, k <= 13, (k <= 13) ? 2'd1 : 2'd0};
      n_checks++;
      if ({note, busy, src} !== e) begin
        n_fail++;
        $display("FAIL key_late k=%0d: got %h/%b/%0d, want %h/%b/%0d", k, note, busy, src, e[10:3], e[2], e[1:0]);
      end
    end
    key_req = '0;
    tick();
  endtask

  task automatic test_done_melody();
    logic [10:0] e;
    done_req = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      tick();
      done_req = 1'b0;
      e = mel_exp(k);
      n_checks++;
      if ({note, busy, src} !== e) begin
        n_fail++;
        $display("FAIL done_melody k=%0d: got %h/%b/%0d, want %h/%b/%0d", k, note, busy, src, e[10:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_preempt();
    logic [10:0] e;
    logic        chk;
    done_req = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      tick();
      done_req = 1'b0;
      chk = 1'b1;
      case (k)
        16:      e = {8'h20, 1'b1, 2'd2};
        17:      e = {8'h04, 1'b1, 2'd3};
        26:      e = {8'h04, 1'b1, 2'd3};
        27:      e = {8'h00, 1'b1, 2'd3};
        30:      e = {8'h01, 1'b1, 2'd3};
        40:      e = {8'h00, 1'b1, 2'd3};
        43:      e = {8'h04, 1'b1, 2'd3};
        45:      e = {8'h04, 1'b1, 2'd3};
        46:      e = {8'h00, 1'b1, 2'd3};
        48:      e = {8'h00, 1'b1, 2'd3};
        49:      e = {8'h80, 1'b1, 2'd2};
        62:      e = {8'h20, 1'b1, 2'd2};
        100:     e = {8'h00, 1'b1, 2'd2};
        101:     e = 11'd0;
        default: begin e = 11'd0; chk = 1'b0; end
      endcase
      if (chk) begin
        n_checks++;
        if ({note, busy, src} !== e) begin
          n_fail++;
          $display("FAIL preempt k=%0d: got %h/%b/%0d, want %h/%b/%0d", k, note, busy, src, e[10:3], e[2], e[1:0]);
        end
      end
      if (k == 16) alarm_en = 1'b1;
      if (k == 45) alarm_en = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    logic [10:0] e;
    key_req  = 8'h02;
    done_req = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      tick();
      done_req = 1'b0;
      e = mel_exp(k);
      n_checks++;
      if ({note, busy, src} !== e) begin
        n_fail++;
        $display("FAIL simultaneous k=%0d: got %h/%b/%0d, want %h/%b/%0d", k, note, busy, src, e[10:3], e[2], e[1:0]);
      end
    end
    key_req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    key_req = 8'h40;
    for (int k = 1; k <= 67; k++) begin
      tick();
      done_req = (k == 4);
      if (k <= 10)      e = {8'h40, 1'b1, 2'd1};
      else if (k <= 13) e = {8'h00, 1'b1, 2'd1};
      else              e = mel_exp(k - 13);
      n_checks++;
      if ({note, busy, src} !== e) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d: got %h/%b/%0d, want %h/%b/%0d", k, note, busy, src, e[10:3], e[2], e[1:0]);
      end
    end
    done_req = 1'b0;
    key_req  = '0;
    tick();
  endtask

  task automatic test_reset_mid_note();
    logic [10:0] e;
    key_req = 8'h80;
    tick(); tick(); tick(); tick();
    n_checks++;
    if ({note, busy, src} !== {8'h80, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL rst_pre: got %h/%b/%0d, want 80/1/1", note, busy, src);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({note, busy, src} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_async: got %h/%b/%0d, want 00/0/0", note, busy, src);
    end
    key_req = '0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if ({note, busy, src} !== 11'd0) begin
        n_fail++;
        $display("FAIL rst_stay_idle k=%0d: got %h/%b/%0d, want 00/0/0", k, note, busy, src);
      end
    end
    // a key held across reset must produce exactly one click after release
    rst_n = 1'b0;
    #1 key_req = 8'h04;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = {(k <= 10) ? 8'h04 : 8'h00, k <= 13, (k <= 13) ? 2'd1 : 2'd0};
      n_checks++;
      if ({note, busy, src} !== e) begin
        n_fail++;
        $display("FAIL rst_held_key k=%0d: got %h/%b/%0d, want %h/%b/%0d", k, note, busy, src, e[10:3], e[2], e[1:0]);
      end
    end
    key_req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_key_click();
    test_invalid_key();
    test_key_late();
    test_done_melody();
    test_preempt();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_note();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
